// File: rtl/bitcounter_control.sv
// Sequencing FSM for the lab bit counter: starts a count on a synchronised
// start level, steps the datapath shift/increment strobes until A empties.
//
// state   | meaning
// S_IDLE  | result cleared, A tracks input_a while start_s is low
// S_COUNT | shift A right each cycle, increment on A[0]; exit once A == 0
// S_DONE  | result final; hold until start_s drops
module bitcounter_control #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             clear,
  output logic             load_a,
  output logic             r_shift,
  output logic             incr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   start_s1_q;
  logic   start_s_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      start_s1_q <= 1'b0;
      start_s_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_s1_q <= start;
      start_s_q  <= start_s1_q;
    end
  end

  // incr looks at A[0] before the same-edge shift, so each set bit counts once
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    load_a  = 1'b0;
    r_shift = 1'b0;
    incr    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        clear  = 1'b1;
        load_a = ~start_s_q;
        if (start_s_q) state_d = S_COUNT;
      end
      S_COUNT: begin
        busy = 1'b1;
        if (A == '0) begin
          state_d = S_DONE;
        end else begin
          r_shift = 1'b1;
          incr    = A[0];
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitcounter_control.sv
// Bench for bitcounter_control: a small behavioural datapath closes the loop,
// a transaction-level model predicts strobes/result each cycle.
module tb_bitcounter_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] input_a = 8'h00;
  logic [7:0] A;
  logic [3:0] result;
  logic       clear, load_a, r_shift, incr, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #10 clock = ~clock;

  bitcounter_control #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .clear  (clear),
    .load_a (load_a),
    .r_shift(r_shift),
    .incr   (incr),
    .busy   (busy),
    .done   (done)
  );

  // datapath stand-in (no reset, as in the real lab datapath)
  always @(posedge clock) begin
    if (clear) result <= 4'd0;
    else if (incr) result <= result + 4'd1;
    if (load_a) A <= input_a;
    else if (r_shift) A <= A >> 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // number of right shifts needed to empty v
  function automatic int span(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // model: phase 0 idle, 1 counting, 2 done
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_pos   = 0;
  int         m_res   = 0;
  bit         m_s1 = 1'b0, m_s = 1'b0, m_cleared = 1'b0;
  logic [7:0] m_opnd = 8'h00;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_s1 = 1'b0; m_s = 1'b0; m_cleared = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_cleared = 1'b1;
          if (m_s) begin
            m_phase = 1; m_left = span(m_opnd) + 1; m_pos = 0;
          end else begin
            m_opnd = input_a;
          end
        end
        1: begin
          m_left--; m_pos++;
          if (m_left == 0) begin
            m_phase = 2; m_res = popc(m_opnd); m_opnd = 8'h00;
          end
        end
        default: if (!m_s) begin m_phase = 0; m_cleared = 1'b0; end
      endcase
      m_s  = m_s1;
      m_s1 = start;
    end
  end

  logic [5:0] c_exp;
  logic [7:0] c_a;
  always @(negedge clock) begin
    c_a = m_opnd >> m_pos;
    case (m_phase)
      0: c_exp = {1'b1, ~m_s, 4'b0000};
      1: c_exp = {2'b00, c_a != 8'h00, c_a[0], 1'b1, 1'b0};
      default: c_exp = 6'b000001;
    endcase
    check("strobes", {clear, load_a, r_shift, incr, busy, done}, c_exp);
    if (m_phase == 1) begin
      check("count_A", A, c_a);
      check("count_partial", result, popc(m_opnd) - popc(c_a));
    end
    if (m_phase == 2) check("done_result", result, m_res);
    if (m_phase == 0 && m_cleared) check("idle_cleared", result, 0);
  end

  task automatic run_count(input logic [7:0] v, output int busy_n, output int edges);
    input_a = v;
    start   = 1'b1;
    busy_n  = 0;
    edges   = 0;
    while (1) begin
      @(posedge clock); edges++;
      @(negedge clock);
      if (busy) busy_n++;
      if (done) break;
      if (edges > 60) begin
        check("timeout_done", edges, 0);
        break;
      end
    end
  endtask

  task automatic drop_start(output int n);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) n++;
      else break;
    end
  endtask

  int b, e, d, t;

  initial begin
    #5;
    check("pre_edge_clear", clear, 1);
    check("pre_edge_load_a", load_a, 1);
    check("pre_edge_busy", busy, 0);
    check("pre_edge_done", done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_count(8'b1011_0010, b, e);
    check("b2_busy_cycles", b, 9);
    check("b2_done_edge", e, 12);
    check("b2_result", result, 4);
    check("b2_A_empty", A, 0);
    drop_start(d);
    check("b2_done_linger", d, 2);
    repeat (2) @(negedge clock);

    run_count(8'hFF, b, e);
    check("ff_busy_cycles", b, 9);
    check("ff_result", result, 8);
    drop_start(d);
    repeat (2) @(negedge clock);

    run_count(8'h00, b, e);
    check("zero_busy_cycles", b, 1);
    check("zero_done_edge", e, 4);
    check("zero_result", result, 0);
    drop_start(d);
    repeat (2) @(negedge clock);

    // start released early in the count: must still finish
    input_a = 8'b1011_0010;
    start   = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    t = 0;
    while (!done && t < 40) begin @(negedge clock); t++; end
    check("drop_done_seen", done, 1);
    check("drop_result", result, 4);
    repeat (3) @(negedge clock);

    // start held through done, operand changes underneath
    run_count(8'b1011_0010, b, e);
    input_a = 8'h0F;
    repeat (5) @(negedge clock);
    check("hold_done", done, 1);
    check("hold_result", result, 4);
    drop_start(d);
    check("hold_done_linger", d, 2);
    repeat (2) @(negedge clock);
    check("relaunch_cleared", result, 0);
    check("relaunch_A_loaded", A, 8'h0F);
    run_count(8'h0F, b, e);
    check("0f_busy_cycles", b, 5);
    check("0f_result", result, 4);
    drop_start(d);
    repeat (2) @(negedge clock);

    // reset in the middle of a count
    input_a = 8'b1011_0000;
    start   = 1'b1;
    t = 0;
    while (!(busy && A == 8'h0B) && t < 40) begin @(negedge clock); t++; end
    check("mid_A_reached", A, 8'h0B);
    #3 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_clear", clear, 1);
    check("async_load_a", load_a, 1);
    start = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
    input_a = 8'h5A;
    @(negedge clock);
    check("post_reset_result", result, 0);
    check("post_reset_A", A, 8'h5A);
    run_count(8'h5A, b, e);
    check("5a_busy_cycles", b, 8);
    check("5a_result", result, 4);
    drop_start(d);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
